// File: rtl/memory_io_responder.sv
// Memory-mapped responder for the processor's ADDR/DOUT/W/DIN bus: word RAM, LED register and timer/switch page.
// Optional macro MEMORY_IO_RESPONDER_SW_SYNC_EN inserts a two-flop synchronizer on SW.
module memory_io_responder #(
    parameter int RAM_DEPTH = 256,
    parameter int PRESCALE  = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [8:0] ADDR,
    input  logic [8:0] DOUT,
    input  logic       W,
    output logic [8:0] DIN,
    input  logic [8:0] SW,
    output logic [8:0] LEDR
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [8:0]  mem_q [0:RAM_DEPTH-1];
    logic [8:0]  din_q, din_d;
    logic [8:0]  led_q, led_d;
    logic [8:0]  tmr_q, tmr_d;
    logic [15:0] pre_q, pre_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;

    logic        ram_sel_s, led_sel_s, tmr_sel_s, tctl_sel_s, sw_sel_s;
    logic        tctl_wr_s, ovf_set_s;
    logic [8:0]  sw_rd_s;

`ifdef MEMORY_IO_RESPONDER_SW_SYNC_EN
    logic [8:0] sw_meta_q, sw_sync_q;

    // Two-stage synchronizer for the asynchronous switch inputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sw_meta_q <= 9'h000;
            sw_sync_q <= 9'h000;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end
    assign sw_rd_s = sw_sync_q;
`else
    assign sw_rd_s = SW;
`endif

    // Address decode
    always_comb begin
        ram_sel_s  = (ADDR[8] == 1'b0) && ({1'b0, ADDR[7:0]} < 9'(RAM_DEPTH));
        led_sel_s  = (ADDR[8:7] == 2'b10);
        tmr_sel_s  = (ADDR == 9'h180);
        tctl_sel_s = (ADDR == 9'h181);
        sw_sel_s   = (ADDR == 9'h182);
        tctl_wr_s  = W && tctl_sel_s;
    end

    // Read mux sees pre-write state, which gives read-first behaviour
    always_comb begin
        din_d = 9'h000;
        if (ram_sel_s) begin
            din_d = mem_q[ADDR[AW-1:0]];
        end else if (led_sel_s) begin
            din_d = led_q;
        end else if (tmr_sel_s) begin
            din_d = tmr_q;
        end else if (tctl_sel_s) begin
            din_d = {6'b000000, ovf_q, 1'b0, en_q};
        end else if (sw_sel_s) begin
            din_d = sw_rd_s;
        end else begin
            din_d = 9'h000;
        end
    end

    // LED register and timer next state; a clear write overrides a tick
    always_comb begin
        led_d     = led_q;
        pre_d     = pre_q;
        tmr_d     = tmr_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        ovf_set_s = 1'b0;
        if (W && led_sel_s) begin
            led_d = DOUT;
        end else begin
            led_d = led_q;
        end
        if (tctl_wr_s && DOUT[1]) begin
            pre_d = 16'h0000;
            tmr_d = 9'h000;
        end else if (en_q) begin
            if (pre_q == 16'(PRESCALE - 1)) begin
                pre_d     = 16'h0000;
                tmr_d     = tmr_q + 9'd1;
                ovf_set_s = (tmr_q == 9'h1FF);
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end else begin
            pre_d = pre_q;
        end
        // A new overflow beats a flag-clear in the same cycle
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (tctl_wr_s && DOUT[2]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (tctl_wr_s) begin
            en_d = DOUT[0];
        end else begin
            en_d = en_q;
        end
    end

    // Control and data registers
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            din_q <= 9'h000;
            led_q <= 9'h000;
            tmr_q <= 9'h000;
            pre_q <= 16'h0000;
            en_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            din_q <= din_d;
            led_q <= led_d;
            tmr_q <= tmr_d;
            pre_q <= pre_d;
            en_q  <= en_d;
            ovf_q <= ovf_d;
        end
    end

    // RAM array, not cleared by reset
    always_ff @(posedge Clock) begin
        if (Resetn && W && ram_sel_s) begin
            mem_q[ADDR[AW-1:0]] <= DOUT;
        end
    end

    assign DIN  = din_q;
    assign LEDR = led_q;

endmodule

// File: tb/tb_memory_io_responder.sv
// Bench for memory_io_responder: reset, table vectors, timer/overflow sequences and randomized traffic vs a reference model.
module tb_memory_io_responder;

    localparam int PRESCALE = 4;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [8:0] ADDR, DOUT, SW;
    logic       W;
    logic [8:0] DIN, LEDR;

    memory_io_responder #(.RAM_DEPTH(256), .PRESCALE(PRESCALE)) dut (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .DIN(DIN), .SW(SW), .LEDR(LEDR)
    );

    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [8:0] m_ram [256];
    bit         m_vld [256];
    logic [8:0] m_led, m_tmr, m_s1, m_s2;
    int         m_pre;
    bit         m_en, m_ovf;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    endtask

    function automatic logic [9:0] model_read(input logic [8:0] a);
        logic [8:0] swv;
`ifdef MEMORY_IO_RESPONDER_SW_SYNC_EN
        swv = m_s2;
`else
        swv = SW;
`endif
        if (a < 9'h100)        return {m_vld[a[7:0]] ? 1'b1 : 1'b0, m_ram[a[7:0]]};
        else if (a < 9'h180)   return {1'b1, m_led};
        else if (a == 9'h180)  return {1'b1, m_tmr};
        else if (a == 9'h181)  return {1'b1, 6'b000000, m_ovf, 1'b0, m_en};
        else if (a == 9'h182)  return {1'b1, swv};
        else                   return {1'b1, 9'h000};
    endfunction

    // One clock edge: apply inputs, advance model, compare just after the edge
    task automatic step(input logic rstn, input logic [8:0] a, input logic [8:0] d, input logic w);
        logic [9:0] exp;
        bit clr, ovf_new;
        Resetn = rstn; ADDR = a; DOUT = d; W = w;
        @(posedge Clock);
        exp = rstn ? model_read(a) : 10'h200;
        if (!rstn) begin
            m_led = 9'h000; m_tmr = 9'h000; m_pre = 0; m_en = 1'b0; m_ovf = 1'b0;
            m_s1 = 9'h000; m_s2 = 9'h000;
        end else begin
            m_s2 = m_s1; m_s1 = SW;
            if (w && a < 9'h100) begin m_ram[a[7:0]] = d; m_vld[a[7:0]] = 1'b1; end
            if (w && a >= 9'h100 && a < 9'h180) m_led = d;
            clr = w && a == 9'h181 && d[1];
            ovf_new = 1'b0;
            if (clr) begin
                m_tmr = 9'h000; m_pre = 0;
            end else if (m_en) begin
                m_pre = m_pre + 1;
                if (m_pre == PRESCALE) begin
                    m_pre = 0;
                    ovf_new = (m_tmr == 9'h1FF);
                    m_tmr = 9'((int'(m_tmr) + 1) % 512);
                end
            end
            if (w && a == 9'h181) begin
                if (d[2]) m_ovf = 1'b0;
                m_en = d[0];
            end
            if (ovf_new) m_ovf = 1'b1;
        end
        #1;
        if (exp[9]) chk("din_model", DIN, exp[8:0]);
        chk("ledr_model", LEDR, m_led);
    endtask

    typedef struct {
        logic [8:0] addr;
        logic [8:0] dout;
        logic       w;
        logic       chk_din;
        logic [8:0] din;
        logic [8:0] ledr;
    } vec_t;

    vec_t tbl[12];
    bit   found;

    initial begin
        for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
        m_led = 9'h000; m_tmr = 9'h000; m_pre = 0; m_en = 1'b0; m_ovf = 1'b0;
        m_s1 = 9'h000; m_s2 = 9'h000;
        Resetn = 1'b0; ADDR = 9'h000; DOUT = 9'h000; W = 1'b0; SW = 9'h0A5;

        tbl[0]  = '{9'h03A, 9'h155, 1'b1, 1'b0, 9'h000, 9'h000};
        tbl[1]  = '{9'h03A, 9'h000, 1'b0, 1'b1, 9'h155, 9'h000};
        tbl[2]  = '{9'h03A, 9'h0AA, 1'b1, 1'b1, 9'h155, 9'h000};
        tbl[3]  = '{9'h03A, 9'h000, 1'b0, 1'b1, 9'h0AA, 9'h000};
        tbl[4]  = '{9'h17F, 9'h1F0, 1'b1, 1'b1, 9'h000, 9'h1F0};
        tbl[5]  = '{9'h100, 9'h000, 1'b0, 1'b1, 9'h1F0, 9'h1F0};
        tbl[6]  = '{9'h180, 9'h123, 1'b1, 1'b1, 9'h000, 9'h1F0};
        tbl[7]  = '{9'h180, 9'h000, 1'b0, 1'b1, 9'h000, 9'h1F0};
        tbl[8]  = '{9'h1C0, 9'h1FF, 1'b1, 1'b1, 9'h000, 9'h1F0};
        tbl[9]  = '{9'h182, 9'h000, 1'b0, 1'b1, 9'h0A5, 9'h1F0};
        tbl[10] = '{9'h181, 9'h000, 1'b0, 1'b1, 9'h000, 9'h1F0};
        tbl[11] = '{9'h03A, 9'h000, 1'b0, 1'b1, 9'h0AA, 9'h1F0};

        // Reset for two cycles, then read cleared registers
        step(1'b0, 9'h100, 9'h1FF, 1'b1);
        step(1'b0, 9'h100, 9'h1FF, 1'b1);
        chk("rst_din", DIN, 9'h000);
        chk("rst_ledr", LEDR, 9'h000);
        step(1'b1, 9'h100, 9'h000, 1'b0); chk("rst_rd_100", DIN, 9'h000);
        step(1'b1, 9'h180, 9'h000, 1'b0); chk("rst_rd_180", DIN, 9'h000);
        step(1'b1, 9'h181, 9'h000, 1'b0); chk("rst_rd_181", DIN, 9'h000);

        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].addr, tbl[i].dout, tbl[i].w);
            if (tbl[i].chk_din) chk($sformatf("tbl%0d_din", i), DIN, tbl[i].din);
            chk($sformatf("tbl%0d_ledr", i), LEDR, tbl[i].ledr);
        end

        // Timer: enable, wait 40 cycles, then clear+enable
        step(1'b1, 9'h181, 9'h001, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 9'h180, 9'h000, 1'b0);
        chk("timer_40", {8'h00, (DIN >= 9'h009 && DIN <= 9'h00B)}, 9'h001);
        step(1'b1, 9'h181, 9'h003, 1'b1);
        step(1'b1, 9'h180, 9'h000, 1'b0);
        chk("timer_clr", {8'h00, (DIN <= 9'h001)}, 9'h001);

        // Overflow flag set, then cleared with enable kept
        for (int i = 0; i < 2060; i++) step(1'b1, 9'h181, 9'h000, 1'b0);
        chk("ovf_set", {8'h00, DIN[2]}, 9'h001);
        step(1'b1, 9'h181, 9'h005, 1'b1);
        step(1'b1, 9'h181, 9'h000, 1'b0);
        chk("ovf_clr", DIN, 9'h001);

        // Flag-clear write on the exact edge of a new overflow
        found = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            if (m_en && m_pre == PRESCALE - 1 && m_tmr == 9'h1FF) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 9'h181, 9'h000, 1'b0);
        end
        chk("ovf_race_reached", {8'h00, found}, 9'h001);
        if (found) begin
            step(1'b1, 9'h181, 9'h005, 1'b1);
            step(1'b1, 9'h181, 9'h000, 1'b0);
            chk("ovf_race", {8'h00, DIN[2]}, 9'h001);
        end

        // Unmapped read, then reset mid-count with an ignored write
        step(1'b1, 9'h1C0, 9'h000, 1'b0); chk("unmapped", DIN, 9'h000);
        for (int i = 0; i < 7; i++) step(1'b1, 9'h180, 9'h000, 1'b0);
        step(1'b0, 9'h03A, 9'h1FF, 1'b1);
        chk("rst2_ledr", LEDR, 9'h000);
        step(1'b1, 9'h03A, 9'h000, 1'b0); chk("ram_retained", DIN, 9'h0AA);
        step(1'b1, 9'h180, 9'h000, 1'b0); chk("rst2_timer", DIN, 9'h000);

        // Switch change latency
        SW = 9'h0F0;
`ifdef MEMORY_IO_RESPONDER_SW_SYNC_EN
        step(1'b1, 9'h182, 9'h000, 1'b0);
        step(1'b1, 9'h182, 9'h000, 1'b0);
        step(1'b1, 9'h182, 9'h000, 1'b0);
`else
        step(1'b1, 9'h182, 9'h000, 1'b0);
`endif
        chk("sw_latency", DIN, 9'h0F0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            SW = 9'($urandom);
            step(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 9'($urandom_range(9'h17E, 9'h183)) : 9'($urandom),
                 9'($urandom),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
